// File: rtl/scene_sequencer_if.sv
// rtl/scene_sequencer_if.sv - sync/control inputs and scene/brightness outputs of the scene sequencer
interface scene_sequencer_if;
    logic       v_sync;
    logic       pause;
    logic       skip;
    logic       frame_tick;
    logic [9:0] anim_ctr;
    logic [1:0] scene;
    logic [1:0] bright;
    logic [2:0] layer_en;

    modport master (
        output v_sync, pause, skip,
        input  frame_tick, anim_ctr, scene, bright, layer_en
    );

    modport slave (
        input  v_sync, pause, skip,
        output frame_tick, anim_ctr, scene, bright, layer_en
    );
endinterface

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-rate scene rotation with fade in/hold/fade out and layer selection
module scene_sequencer #(
    parameter int FADE_STEP_FRAMES = 8,
    parameter int HOLD_FRAMES      = 240,
    parameter int NUM_SCENES       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    scene_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_FADE_IN  = 2'd0,
        ST_HOLD     = 2'd1,
        ST_FADE_OUT = 2'd2,
        ST_SWITCH   = 2'd3
    } state_t;

    localparam logic [9:0] FADE_LAST  = 10'(FADE_STEP_FRAMES - 1);
    localparam logic [9:0] HOLD_LAST  = 10'(HOLD_FRAMES - 1);
    localparam logic [1:0] SCENE_LAST = 2'(NUM_SCENES - 1);

    state_t     state_q, state_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] bright_q, bright_d;
    logic [1:0] scene_q, scene_d;
    logic [9:0] anim_ctr_q, anim_ctr_d;
    logic       skip_req_q, skip_req_d;
    logic       v_sync_q;
    logic       armed_q, armed_d;
    logic       frame_tick_q;
    logic       frame_edge;
    logic       advance;
    logic       skip_pend;

    // armed_q keeps a v_sync level held high across reset from posing as a fresh edge
    assign frame_edge = bus.v_sync & ~v_sync_q & armed_q;
    assign advance    = frame_edge & ~bus.pause;
    assign skip_pend  = skip_req_q | bus.skip;
    assign armed_d    = armed_q | ~bus.v_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FADE_IN;
            frame_cnt_q  <= '0;
            bright_q     <= '0;
            scene_q      <= '0;
            anim_ctr_q   <= '0;
            skip_req_q   <= 1'b0;
            v_sync_q     <= 1'b0;
            armed_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            bright_q     <= bright_d;
            scene_q      <= scene_d;
            anim_ctr_q   <= anim_ctr_d;
            skip_req_q   <= skip_req_d;
            v_sync_q     <= bus.v_sync;
            armed_q      <= armed_d;
            frame_tick_q <= frame_edge;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        bright_d    = bright_q;
        scene_d     = scene_q;
        anim_ctr_d  = anim_ctr_q;
        skip_req_d  = skip_pend;
        if (advance) begin
            anim_ctr_d = anim_ctr_q + {8'd0, scene_q} + 10'd1;
            skip_req_d = 1'b0;
            case (state_q)
                ST_FADE_IN: begin
                    if (skip_pend) begin
                        state_d     = ST_FADE_OUT;
                        frame_cnt_d = '0;
                    end else if (frame_cnt_q == FADE_LAST) begin
                        frame_cnt_d = '0;
                        if (bright_q >= 2'd2) begin
                            bright_d = 2'd3;
                            state_d  = ST_HOLD;
                        end else begin
                            bright_d = bright_q + 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 10'd1;
                    end
                end
                ST_HOLD: begin
                    if (skip_pend || frame_cnt_q == HOLD_LAST) begin
                        state_d     = ST_FADE_OUT;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 10'd1;
                    end
                end
                ST_FADE_OUT: begin
                    if (frame_cnt_q == FADE_LAST) begin
                        frame_cnt_d = '0;
                        if (bright_q <= 2'd1) begin
                            bright_d = 2'd0;
                            state_d  = ST_SWITCH;
                        end else begin
                            bright_d = bright_q - 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 10'd1;
                    end
                end
                ST_SWITCH: begin
                    scene_d     = (scene_q == SCENE_LAST) ? 2'd0 : scene_q + 2'd1;
                    frame_cnt_d = '0;
                    state_d     = ST_FADE_IN;
                end
            endcase
        end
    end

    always_comb begin
        case (scene_q)
            2'd0:    bus.layer_en = 3'b111;
            2'd1:    bus.layer_en = 3'b011;
            2'd2:    bus.layer_en = 3'b110;
            default: bus.layer_en = 3'b101;
        endcase
    end

    assign bus.frame_tick = frame_tick_q;
    assign bus.anim_ctr   = anim_ctr_q;
    assign bus.scene      = scene_q;
    assign bus.bright     = bright_q;
endmodule
